sdram_wb_bridge: RTL and testbench



---
 rtl/sdram_wb_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_sdram_wb_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wb_bridge.sv
// sdram_wb_bridge
//   Adapter between the processor memory port (strobe-and-hold bus with a
//   level acknowledge) and the SDRAM controller's request/ack interface.
//   It stretches the controller reset and latches the address, write data
//   and byte masks for each transaction. It issues one read or write
//   request at a time and aborts a request that the controller never
//   acknowledges.
//
// Build option:
//   SDRAM_RDBUF_EN  - adds a one-word read buffer. A read that hits it is
//                     acknowledged the cycle after the strobe is seen,
//                     with no controller request.
//
// Ports:
//   clk_p, rst                       clock, synchronous active-high reset
//   sdram_stb/we/sel/adr/out         bus request, held until acknowledged
//   sdram_dat, sdram_ack             read data and level acknowledge
//   sdram_ready                      controller initialised, bridge serving
//   sdram_tmo                        sticky request-timeout flag
//   ctl_rst_n, ctl_init_done         controller reset / init handshake
//   ctl_wr_req/ctl_rd_req            request levels to the controller
//   ctl_wr_ack/ctl_rd_ack            single-cycle controller acks
//   ctl_addr, ctl_wdata, ctl_rdata   address and data to/from controller
//   ctl_udqm, ctl_ldqm               byte masks, 1 = byte masked

module sdram_wb_bridge #(
    parameter int RST_DLY = 3,    // 1..15
    parameter int ACK_DLY = 1,    // 0..3
    parameter int TIMEOUT = 255   // 1..255
) (
    input  logic        clk_p,
    input  logic        rst,
    input  logic        sdram_stb,
    input  logic        sdram_we,
    input  logic [1:0]  sdram_sel,
    input  logic [21:1] sdram_adr,
    input  logic [15:0] sdram_out,
    output logic [15:0] sdram_dat,
    output logic        sdram_ack,
    output logic        sdram_ready,
    output logic        sdram_tmo,
    output logic        ctl_rst_n,
    input  logic        ctl_init_done,
    output logic        ctl_wr_req,
    output logic        ctl_rd_req,
    input  logic        ctl_wr_ack,
    input  logic        ctl_rd_ack,
    output logic [21:0] ctl_addr,
    output logic [15:0] ctl_wdata,
    input  logic [15:0] ctl_rdata,
    output logic        ctl_udqm,
    output logic        ctl_ldqm
);

    typedef enum logic [2:0] {
        S_RST, S_INIT, S_IDLE, S_REQ, S_DLY, S_ACK, S_DRAIN
    } state_t;

    localparam logic [3:0] RST_LAST = 4'(RST_DLY - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] DLY_LAST = 2'(ACK_DLY - 1);

    state_t      state;
    logic [3:0]  rst_cnt;
    logic [7:0]  tmo_cnt;
    logic [1:0]  dly_cnt;
    logic        we_q;

    logic        ack_match;
    logic        rd_capture;
    logic        tmo_fire;
    logic        buf_hit;
    logic [15:0] buf_dat;

    // Only the ack matching the outstanding request type counts.
    assign ack_match  = we_q ? ctl_wr_ack : ctl_rd_ack;

    // Read data is taken on the ack edge when there is no delay, otherwise
    // on the last delay cycle; the controller holds ctl_rdata meanwhile.
    assign rd_capture = !we_q &&
                        (((state == S_REQ) && ack_match && (ACK_DLY == 0)) ||
                         ((state == S_DLY) && (dly_cnt == DLY_LAST)));

    assign tmo_fire   = (state == S_REQ) && !ack_match && (tmo_cnt == TMO_LAST);

`ifdef SDRAM_RDBUF_EN
    logic [21:1] buf_adr;
    logic        buf_vld;

    assign buf_hit = buf_vld && (buf_adr == sdram_adr);

    // NOTE: only the valid bit is reset; address and data are don't-care
    // until the first fill, so they stay plain data registers.
    always_ff @(posedge clk_p) begin
        if (rst) begin
            buf_vld <= 1'b0;
        end else if (rd_capture) begin
            buf_adr <= ctl_addr[20:0];
            buf_dat <= ctl_rdata;
            buf_vld <= 1'b1;
        end else if (tmo_fire) begin
            buf_vld <= 1'b0;
        end else if ((state == S_IDLE) && ctl_init_done && sdram_stb &&
                     sdram_we && buf_hit) begin
            buf_vld <= 1'b0;
        end
    end
`else
    assign buf_hit = 1'b0;
    assign buf_dat = 16'h0000;
`endif

    // NOTE: every state register is assigned with <= so all branches see
    // the values from before the edge, regardless of statement order.
    always_ff @(posedge clk_p) begin
        if (rst) begin
            state       <= S_RST;
            rst_cnt     <= 4'd0;
            tmo_cnt     <= 8'd0;
            dly_cnt     <= 2'd0;
            we_q        <= 1'b0;
            ctl_rst_n   <= 1'b0;
            ctl_wr_req  <= 1'b0;
            ctl_rd_req  <= 1'b0;
            sdram_ack   <= 1'b0;
            sdram_ready <= 1'b0;
            sdram_tmo   <= 1'b0;
            sdram_dat   <= 16'h0000;
            ctl_udqm    <= 1'b1;
            ctl_ldqm    <= 1'b1;
            ctl_addr    <= 22'h0;
            ctl_wdata   <= 16'h0000;
        end else begin
            case (state)
                S_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        ctl_rst_n <= 1'b1;
                        state     <= S_INIT;
                    end else begin
                        rst_cnt <= rst_cnt + 4'd1;
                    end
                end
                S_INIT: begin
                    if (ctl_init_done) begin
                        sdram_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (!ctl_init_done) begin
                        state <= S_DRAIN;
                    end else if (sdram_stb) begin
                        we_q      <= sdram_we;
                        ctl_addr  <= {1'b0, sdram_adr};
                        ctl_wdata <= sdram_out;
                        ctl_udqm  <= sdram_we ? ~sdram_sel[1] : 1'b0;
                        ctl_ldqm  <= sdram_we ? ~sdram_sel[0] : 1'b0;
                        tmo_cnt   <= 8'd0;
                        dly_cnt   <= 2'd0;
                        if (!sdram_we && buf_hit) begin
                            sdram_dat <= buf_dat;
                            sdram_ack <= 1'b1;
                            state     <= S_ACK;
                        end else begin
                            ctl_wr_req <= sdram_we;
                            ctl_rd_req <= !sdram_we;
                            state      <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (ack_match) begin
                        ctl_wr_req <= 1'b0;
                        ctl_rd_req <= 1'b0;
                        if (ACK_DLY == 0) begin
                            if (rd_capture) sdram_dat <= ctl_rdata;
                            sdram_ack <= sdram_stb;
                            state     <= S_ACK;
                        end else begin
                            state <= S_DLY;
                        end
                    end else if (tmo_fire) begin
                        ctl_wr_req <= 1'b0;
                        ctl_rd_req <= 1'b0;
                        sdram_tmo  <= 1'b1;
                        sdram_dat  <= 16'hFFFF;
                        sdram_ack  <= sdram_stb;
                        state      <= S_ACK;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_DLY: begin
                    if (dly_cnt == DLY_LAST) begin
                        if (rd_capture) sdram_dat <= ctl_rdata;
                        sdram_ack <= sdram_stb;
                        state     <= S_ACK;
                    end else begin
                        dly_cnt <= dly_cnt + 2'd1;
                    end
                end
                S_ACK: begin
                    // An aborted transaction arrives here with ack already 0
                    // and leaves on the next edge.
                    if (!sdram_stb) begin
                        sdram_ack <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    sdram_ready <= 1'b0;
                    state       <= S_INIT;
                end
                default: state <= S_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Directed bench for sdram_wb_bridge (RST_DLY=3, ACK_DLY=1, TIMEOUT=16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// The controller model holds ctl_rdata stable after its read ack.

module tb_sdram_wb_bridge;

    logic        clk_p;
    logic        rst;
    logic        sdram_stb;
    logic        sdram_we;
    logic [1:0]  sdram_sel;
    logic [21:1] sdram_adr;
    logic [15:0] sdram_out;
    logic [15:0] sdram_dat;
    logic        sdram_ack;
    logic        sdram_ready;
    logic        sdram_tmo;
    logic        ctl_rst_n;
    logic        ctl_init_done;
    logic        ctl_wr_req;
    logic        ctl_rd_req;
    logic        ctl_wr_ack;
    logic        ctl_rd_ack;
    logic [21:0] ctl_addr;
    logic [15:0] ctl_wdata;
    logic [15:0] ctl_rdata;
    logic        ctl_udqm;
    logic        ctl_ldqm;

    int vectors = 0;
    int miscompares = 0;

    sdram_wb_bridge #(.RST_DLY(3), .ACK_DLY(1), .TIMEOUT(16)) dut (
        .clk_p(clk_p), .rst(rst),
        .sdram_stb(sdram_stb), .sdram_we(sdram_we), .sdram_sel(sdram_sel),
        .sdram_adr(sdram_adr), .sdram_out(sdram_out), .sdram_dat(sdram_dat),
        .sdram_ack(sdram_ack), .sdram_ready(sdram_ready), .sdram_tmo(sdram_tmo),
        .ctl_rst_n(ctl_rst_n), .ctl_init_done(ctl_init_done),
        .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req),
        .ctl_wr_ack(ctl_wr_ack), .ctl_rd_ack(ctl_rd_ack),
        .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_rdata(ctl_rdata),
        .ctl_udqm(ctl_udqm), .ctl_ldqm(ctl_ldqm)
    );

    initial clk_p = 1'b0;
    always #5 clk_p = ~clk_p;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    // One complete bus transaction; the controller acks immediately.
    task automatic run_txn(input logic we, input logic [21:1] adr,
                           input logic [1:0] sel, input logic [15:0] wdat,
                           input logic [15:0] rdat, output logic saw_req,
                           output logic got_ack, output logic [15:0] got_dat);
        sdram_stb = 1'b1; sdram_we = we; sdram_sel = sel;
        sdram_adr = adr; sdram_out = wdat;
        tick();
        saw_req = ctl_wr_req | ctl_rd_req;
        got_ack = 1'b0;
        got_dat = 16'h0000;
        if (saw_req) begin
            ctl_rdata = rdat;
            if (we) ctl_wr_ack = 1'b1; else ctl_rd_ack = 1'b1;
            tick();
            ctl_wr_ack = 1'b0; ctl_rd_ack = 1'b0;
        end
        for (int i = 0; i < 8 && !got_ack; i++) begin
            if (sdram_ack) begin
                got_ack = 1'b1;
                got_dat = sdram_dat;
            end else begin
                tick();
            end
        end
        sdram_stb = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; sdram_stb = 1'b0; sdram_we = 1'b0; sdram_sel = 2'b00;
        sdram_adr = '0; sdram_out = '0; ctl_init_done = 1'b0;
        ctl_wr_ack = 1'b0; ctl_rd_ack = 1'b0; ctl_rdata = '0;
        tick(); tick();
        vectors++; if (ctl_rst_n !== 1'b0) begin miscompares++; $display("FAIL rst_ctl_rst_n: got %b want 0", ctl_rst_n); end
        vectors++; if ({ctl_wr_req, ctl_rd_req} !== 2'b00) begin miscompares++; $display("FAIL rst_reqs: got %b want 00", {ctl_wr_req, ctl_rd_req}); end
        vectors++; if ({sdram_ack, sdram_ready, sdram_tmo} !== 3'b000) begin miscompares++; $display("FAIL rst_ack_ready_tmo: got %b want 000", {sdram_ack, sdram_ready, sdram_tmo}); end
        vectors++; if (sdram_dat !== 16'h0000) begin miscompares++; $display("FAIL rst_dat: got %h want 0000", sdram_dat); end
        vectors++; if ({ctl_udqm, ctl_ldqm} !== 2'b11) begin miscompares++; $display("FAIL rst_dqm: got %b want 11", {ctl_udqm, ctl_ldqm}); end
        vectors++; if (ctl_addr !== 22'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 000000", ctl_addr); end
        vectors++; if (ctl_wdata !== 16'h0000) begin miscompares++; $display("FAIL rst_wdata: got %h want 0000", ctl_wdata); end
        rst = 1'b0;
        tick(); tick();
        vectors++; if (ctl_rst_n !== 1'b0) begin miscompares++; $display("FAIL ctl_rst_n_cycle2: got %b want 0", ctl_rst_n); end
        tick();
        vectors++; if (ctl_rst_n !== 1'b1) begin miscompares++; $display("FAIL ctl_rst_n_cycle3: got %b want 1", ctl_rst_n); end
        for (int c = 4; c <= 20; c++) tick();
        vectors++; if (sdram_ready !== 1'b0) begin miscompares++; $display("FAIL ready_cycle20: got %b want 0", sdram_ready); end
        ctl_init_done = 1'b1;
        tick();
        vectors++; if (sdram_ready !== 1'b1) begin miscompares++; $display("FAIL ready_cycle21: got %b want 1", sdram_ready); end
    endtask

    task automatic test_write();
        sdram_stb = 1'b1; sdram_we = 1'b1; sdram_sel = 2'b10;
        sdram_adr = 21'h12345; sdram_out = 16'hBEEF;
        tick();
        vectors++; if ({ctl_wr_req, ctl_rd_req} !== 2'b10) begin miscompares++; $display("FAIL wr_req_rise: got %b want 10", {ctl_wr_req, ctl_rd_req}); end
        vectors++; if (ctl_addr !== 22'h012345) begin miscompares++; $display("FAIL wr_addr: got %h want 012345", ctl_addr); end
        vectors++; if ({ctl_udqm, ctl_ldqm} !== 2'b01) begin miscompares++; $display("FAIL wr_dqm: got %b want 01", {ctl_udqm, ctl_ldqm}); end
        vectors++; if (ctl_wdata !== 16'hBEEF) begin miscompares++; $display("FAIL wr_wdata: got %h want beef", ctl_wdata); end
        for (int i = 0; i < 3; i++) tick();
        vectors++; if ({ctl_wr_req, sdram_ack} !== 2'b10) begin miscompares++; $display("FAIL wr_req_hold: got req,ack=%b want 10", {ctl_wr_req, sdram_ack}); end
        ctl_wr_ack = 1'b1;
        tick();
        ctl_wr_ack = 1'b0;
        vectors++; if ({ctl_wr_req, sdram_ack} !== 2'b00) begin miscompares++; $display("FAIL wr_req_drop: got req,ack=%b want 00", {ctl_wr_req, sdram_ack}); end
        tick();
        vectors++; if (sdram_ack !== 1'b1) begin miscompares++; $display("FAIL wr_ack_rise: got %b want 1", sdram_ack); end
        tick();
        vectors++; if (sdram_ack !== 1'b1) begin miscompares++; $display("FAIL wr_ack_hold: got %b want 1", sdram_ack); end
        sdram_stb = 1'b0;
        tick();
        vectors++; if (sdram_ack !== 1'b0) begin miscompares++; $display("FAIL wr_ack_fall: got %b want 0", sdram_ack); end
    endtask

    task automatic test_read();
        sdram_stb = 1'b1; sdram_we = 1'b0; sdram_sel = 2'b11; sdram_adr = 21'h00ABC;
        tick();
        vectors++; if ({ctl_wr_req, ctl_rd_req} !== 2'b01) begin miscompares++; $display("FAIL rd_req_rise: got %b want 01", {ctl_wr_req, ctl_rd_req}); end
        vectors++; if ({ctl_udqm, ctl_ldqm} !== 2'b00) begin miscompares++; $display("FAIL rd_dqm: got %b want 00", {ctl_udqm, ctl_ldqm}); end
        vectors++; if (ctl_addr !== 22'h000ABC) begin miscompares++; $display("FAIL rd_addr: got %h want 000abc", ctl_addr); end
        ctl_wr_ack = 1'b1;
        tick();
        ctl_wr_ack = 1'b0;
        vectors++; if ({ctl_rd_req, sdram_ack} !== 2'b10) begin miscompares++; $display("FAIL rd_wrong_ack_ignored: got req,ack=%b want 10", {ctl_rd_req, sdram_ack}); end
        ctl_rdata = 16'h5A5A; ctl_rd_ack = 1'b1;
        tick();
        ctl_rd_ack = 1'b0;
        vectors++; if (ctl_rd_req !== 1'b0) begin miscompares++; $display("FAIL rd_req_drop: got %b want 0", ctl_rd_req); end
        tick();
        vectors++; if ({sdram_ack, sdram_dat} !== {1'b1, 16'h5A5A}) begin miscompares++; $display("FAIL rd_ack_data: got ack=%b dat=%h want ack=1 dat=5a5a", sdram_ack, sdram_dat); end
        sdram_stb = 1'b0; ctl_rdata = 16'h0000;
        tick();
        vectors++; if (sdram_ack !== 1'b0) begin miscompares++; $display("FAIL rd_ack_fall: got %b want 0", sdram_ack); end
    endtask

    task automatic test_abort();
        logic ack_seen, saw_req, got_ack;
        logic [15:0] got_dat;
        ack_seen = 1'b0;
        sdram_stb = 1'b1; sdram_we = 1'b1; sdram_sel = 2'b11;
        sdram_adr = 21'h00100; sdram_out = 16'h1234;
        tick();
        tick(); tick();
        sdram_stb = 1'b0;
        tick(); tick();
        vectors++; if ({ctl_wr_req, sdram_ack} !== 2'b10) begin miscompares++; $display("FAIL abort_req_still_held: got req,ack=%b want 10", {ctl_wr_req, sdram_ack}); end
        ctl_wr_ack = 1'b1;
        tick();
        ctl_wr_ack = 1'b0;
        ack_seen = sdram_ack;
        for (int i = 0; i < 3; i++) begin
            tick();
            ack_seen = ack_seen | sdram_ack;
        end
        vectors++; if (ack_seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_ack: got %b want 0", ack_seen); end
        run_txn(1'b0, 21'h00200, 2'b11, 16'h0000, 16'h1111, saw_req, got_ack, got_dat);
        vectors++; if ({saw_req, got_ack, got_dat} !== {2'b11, 16'h1111}) begin miscompares++; $display("FAIL abort_next_txn: got req=%b ack=%b dat=%h want 1 1 1111", saw_req, got_ack, got_dat); end
    endtask

    task automatic test_timeout();
        logic ack_seen;
        ack_seen = 1'b0;
        sdram_stb = 1'b1; sdram_we = 1'b0; sdram_adr = 21'h00300;
        tick();
        vectors++; if (ctl_rd_req !== 1'b1) begin miscompares++; $display("FAIL tmo_req_rise: got %b want 1", ctl_rd_req); end
        for (int i = 0; i < 15; i++) begin
            tick();
            ack_seen = ack_seen | sdram_ack;
        end
        vectors++; if ({ack_seen, ctl_rd_req, sdram_tmo} !== 3'b010) begin miscompares++; $display("FAIL tmo_before_limit: got ack,req,tmo=%b want 010", {ack_seen, ctl_rd_req, sdram_tmo}); end
        tick();
        vectors++; if ({sdram_ack, sdram_tmo, ctl_rd_req} !== 3'b110) begin miscompares++; $display("FAIL tmo_fire: got ack,tmo,req=%b want 110", {sdram_ack, sdram_tmo, ctl_rd_req}); end
        vectors++; if (sdram_dat !== 16'hFFFF) begin miscompares++; $display("FAIL tmo_dat: got %h want ffff", sdram_dat); end
        sdram_stb = 1'b0;
        tick();
        vectors++; if ({sdram_ack, sdram_tmo} !== 2'b01) begin miscompares++; $display("FAIL tmo_sticky: got ack,tmo=%b want 01", {sdram_ack, sdram_tmo}); end
        tick();
    endtask

    task automatic test_rdbuf();
        logic saw_req, got_ack;
        logic [15:0] got_dat;
        run_txn(1'b0, 21'h00400, 2'b00, 16'h0000, 16'h7777, saw_req, got_ack, got_dat);
        vectors++; if ({got_ack, got_dat} !== {1'b1, 16'h7777}) begin miscompares++; $display("FAIL buf_first_read: got ack=%b dat=%h want 1 7777", got_ack, got_dat); end
`ifdef SDRAM_RDBUF_EN
        sdram_stb = 1'b1; sdram_we = 1'b0; sdram_adr = 21'h00400; ctl_rdata = 16'h0BAD;
        tick();
        vectors++; if ({sdram_ack, ctl_rd_req, sdram_dat} !== {2'b10, 16'h7777}) begin miscompares++; $display("FAIL buf_hit: got ack=%b req=%b dat=%h want 1 0 7777", sdram_ack, ctl_rd_req, sdram_dat); end
        sdram_stb = 1'b0;
        tick(); tick();
`else
        run_txn(1'b0, 21'h00400, 2'b00, 16'h0000, 16'h0BAD, saw_req, got_ack, got_dat);
        vectors++; if ({saw_req, got_dat} !== {1'b1, 16'h0BAD}) begin miscompares++; $display("FAIL nobuf_second_read: got req=%b dat=%h want 1 0bad", saw_req, got_dat); end
`endif
        run_txn(1'b1, 21'h00400, 2'b11, 16'h4444, 16'h0000, saw_req, got_ack, got_dat);
        vectors++; if ({saw_req, got_ack} !== 2'b11) begin miscompares++; $display("FAIL buf_write: got req=%b ack=%b want 1 1", saw_req, got_ack); end
        run_txn(1'b0, 21'h00400, 2'b00, 16'h0000, 16'h5555, saw_req, got_ack, got_dat);
        vectors++; if ({saw_req, got_ack, got_dat} !== {2'b11, 16'h5555}) begin miscompares++; $display("FAIL buf_after_write: got req=%b ack=%b dat=%h want 1 1 5555", saw_req, got_ack, got_dat); end
    endtask

    task automatic test_drain();
        ctl_init_done = 1'b0;
        sdram_stb = 1'b1; sdram_we = 1'b0; sdram_adr = 21'h00500;
        tick();
        vectors++; if ({sdram_ready, ctl_rd_req} !== 2'b10) begin miscompares++; $display("FAIL drain_enter: got ready,req=%b want 10", {sdram_ready, ctl_rd_req}); end
        tick();
        vectors++; if ({sdram_ready, ctl_rd_req} !== 2'b00) begin miscompares++; $display("FAIL drain_to_init: got ready,req=%b want 00", {sdram_ready, ctl_rd_req}); end
        sdram_stb = 1'b0; ctl_init_done = 1'b1;
        tick();
        vectors++; if (sdram_ready !== 1'b1) begin miscompares++; $display("FAIL drain_reinit: got %b want 1", sdram_ready); end
    endtask

    task automatic test_rst_mid();
        sdram_stb = 1'b1; sdram_we = 1'b1; sdram_sel = 2'b01;
        sdram_adr = 21'h00600; sdram_out = 16'hAAAA;
        tick();
        vectors++; if (ctl_wr_req !== 1'b1) begin miscompares++; $display("FAIL rstmid_req: got %b want 1", ctl_wr_req); end
        rst = 1'b1;
        tick();
        vectors++; if ({ctl_wr_req, ctl_rst_n, sdram_ready, sdram_tmo} !== 4'b0000) begin miscompares++; $display("FAIL rstmid_ctrl: got req,rst_n,ready,tmo=%b want 0000", {ctl_wr_req, ctl_rst_n, sdram_ready, sdram_tmo}); end
        vectors++; if ({ctl_udqm, ctl_ldqm, ctl_addr, ctl_wdata, sdram_dat} !== {2'b11, 22'h0, 16'h0, 16'h0}) begin miscompares++; $display("FAIL rstmid_data: got dqm=%b addr=%h wdata=%h dat=%h want 11 0 0 0", {ctl_udqm, ctl_ldqm}, ctl_addr, ctl_wdata, sdram_dat); end
        sdram_stb = 1'b0; rst = 1'b0;
        tick(); tick(); tick();
        vectors++; if (ctl_rst_n !== 1'b1) begin miscompares++; $display("FAIL rstmid_release: got %b want 1", ctl_rst_n); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_timeout();
        test_rdbuf();
        test_drain();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
